bram_word_loader: RTL

- Upstream feeder for the wide-word BRAM wrapper.
- Accepts a byte stream with valid/ready, packs bytes into WIDTH-bit words, and writes each word to consecutive wrapper addresses.
- Issues one write pulse per word and waits for the wrapper's completion strobe before accepting the next word.
- Used to load weight/activation memories from the host byte link.

---
 rtl/bram_loader_pkg.sv | 17 +
 rtl/bram_word_loader_byte_packer.sv | 46 ++++
 rtl/bram_word_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bram_loader_pkg.sv
// Shared types and helpers for the BRAM word loader: FSM state encoding and
// the address wrap rule used when stepping through wrapper addresses.
package bram_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WRITE,
      S_WAIT,
      S_DONE
   } state_t;

   function automatic int unsigned next_addr(input int unsigned addr, input int unsigned addrs);
      return (addr >= addrs - 32'd1) ? 32'd0 : addr + 32'd1;
   endfunction

endpackage

// File: rtl/bram_word_loader_byte_packer.sv
// Little-endian byte assembler: each load drops a byte into the next lane of
// the word register; clear restarts at lane 0 with an all-zero word.
module byte_packer #(
   parameter  int unsigned BYTES = 32,
   localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 clear_in,
   input  logic                 load_in,
   input  logic [7:0]           byte_in,
   output logic [8*BYTES-1:0]   data_out,
   output logic                 last_out
);

   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [8*BYTES-1:0] data_q, data_d;

   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      if (clear_in) begin
         idx_d  = '0;
         data_d = '0;
      end else if (load_in) begin
         for (int unsigned i = 0; i < BYTES; i++) begin
            if (idx_q == IDX_W'(i)) data_d[8*i +: 8] = byte_in;
         end
         idx_d = (idx_q == IDX_W'(BYTES - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

   assign data_out = data_q;
   assign last_out = (idx_q == IDX_W'(BYTES - 1));

endmodule

// File: rtl/bram_word_loader.sv
// Packs a byte stream into wide words and writes them to consecutive wrapper
// addresses, one write per word, waiting for the wrapper's finished strobe.
module bram_word_loader
   import bram_loader_pkg::*;
#(
   parameter  int unsigned ADDRS      = 24,
   parameter  int unsigned BRAM_WIDTH = 64,
   parameter  int unsigned PIECES     = 4,
   localparam int unsigned WIDTH      = BRAM_WIDTH * PIECES,
   localparam int unsigned BYTES      = WIDTH / 8,
   localparam int unsigned ADDR_SIZE  = $clog2(ADDRS)
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [ADDR_SIZE-1:0] base_addr_in,
   input  logic [ADDR_SIZE:0]   count_in,
   input  logic                 abort_in,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid_in,
   output logic                 byte_ready_out,
   output logic [ADDR_SIZE-1:0] addr_out,
   output logic [WIDTH-1:0]     data_out,
   output logic                 write_enable_out,
   input  logic                 finished_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [ADDR_SIZE:0]   words_written_out
);

   if (BRAM_WIDTH % 8 != 0) begin : g_width_check
      $error("BRAM_WIDTH must be a multiple of 8");
   end

   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [ADDR_SIZE:0]   count_q, count_d;
   logic [ADDR_SIZE:0]   words_q, words_d;
   logic [ADDR_SIZE:0]   words_inc;
   logic                 ready_q, ready_d;
   logic                 we_q, we_d;
   logic                 done_q, done_d;
   logic                 clear;
   logic                 load;
   logic                 last;
   logic                 busy;

   assign load = byte_valid_in & ready_q;
   assign busy = (state_q != S_IDLE);

   byte_packer #(.BYTES(BYTES)) u_packer (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clear_in (clear),
      .load_in  (load),
      .byte_in  (byte_in),
      .data_out (data_out),
      .last_out (last)
   );

   // Outputs are registered for the state being entered, so each branch
   // sets ready/we/done for the next cycle alongside state_d.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      words_d   = words_q;
      ready_d   = 1'b0;
      we_d      = 1'b0;
      done_d    = 1'b0;
      clear     = 1'b0;
      words_inc = words_q + (ADDR_SIZE+1)'(1);
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               if (count_in != '0) begin
                  addr_d  = base_addr_in;
                  count_d = count_in;
                  words_d = '0;
                  clear   = 1'b1;
                  ready_d = 1'b1;
                  state_d = S_FILL;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_FILL: begin
            if (abort_in) begin
               state_d = S_IDLE;
            end else if (load && last) begin
               we_d    = 1'b1;
               state_d = S_WRITE;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_WRITE: state_d = abort_in ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (abort_in) begin
               state_d = S_IDLE;
            end else if (finished_in) begin
               words_d = words_inc;
               if (words_inc == count_q) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  addr_d  = ADDR_SIZE'(next_addr(32'(addr_q), ADDRS));
                  clear   = 1'b1;
                  ready_d = 1'b1;
                  state_d = S_FILL;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         words_q <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         words_q <= words_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

   // Abort must be able to cancel a pulse already registered for this cycle.
   assign write_enable_out  = we_q & ~abort_in;
   assign done_out          = done_q & ~(abort_in & busy);
   assign byte_ready_out    = ready_q;
   assign busy_out          = busy;
   assign addr_out          = addr_q;
   assign words_written_out = words_q;

endmodule
